// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter_pkg
// Description : Shared requester indices, FSM state type and helpers for the
//               SRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_port_arbiter_pkg;

    localparam logic [1:0] REQ_SLAVE_WR  = 2'd0;
    localparam logic [1:0] REQ_SLAVE_RD  = 2'd1;
    localparam logic [1:0] REQ_MASTER_WR = 2'd2;
    localparam logic [1:0] REQ_MASTER_RD = 2'd3;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HINT = 2'd1,
        RELEASE   = 2'd2
    } arb_state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin picker; search starts at
//               last+1 and the first eligible index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4 (
    input  logic [3:0] eligible,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest eligible index
    // (starting at last+1) is the final assignment.
    always_comb begin
        winner = 2'd0;
        w_idx  = 2'd0;
        any    = |eligible;
        for (int k = 4; k >= 1; k--) begin
            w_idx = last + 2'(k);
            if (eligible[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Round-robin arbiter sharing the single-port SRAM FIFO
//               controller between four SPI requesters, with hint watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] wdata_slave,
    input  logic [DATA_W-1:0] wdata_master,
    input  logic              fifo_i_full,
    input  logic              fifo_i_empty,
    input  logic              fifo_o_full,
    input  logic              fifo_o_empty,
    output logic [3:0]        sram_cmd,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_hint,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [3:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [1:0]        r_last;
    logic [1:0]        r_idx;
    logic [3:0]        r_cmd;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_cnt;

    logic [3:0]        w_eligible;
    logic [1:0]        w_winner;
    logic              w_any;
    logic              w_issue;
    logic              w_complete;
    logic              w_abort;

    assign w_eligible[REQ_SLAVE_WR]  = req[REQ_SLAVE_WR]  & ~fifo_i_full;
    assign w_eligible[REQ_SLAVE_RD]  = req[REQ_SLAVE_RD]  & ~fifo_o_empty;
    assign w_eligible[REQ_MASTER_WR] = req[REQ_MASTER_WR] & ~fifo_o_full;
    assign w_eligible[REQ_MASTER_RD] = req[REQ_MASTER_RD] & ~fifo_i_empty;

    rr_pick4 u_pick (
        .eligible (w_eligible),
        .last     (r_last),
        .winner   (w_winner),
        .any      (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Hint takes precedence over a coincident watchdog expiry.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_issue      = 1'b1;
                    w_state_next = WAIT_HINT;
                end
            end
            WAIT_HINT: begin
                if (sram_hint) begin
                    w_complete   = 1'b1;
                    w_state_next = RELEASE;
                end else if (r_cnt == c_cnt_last) begin
                    w_abort      = 1'b1;
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!sram_hint) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last        <= REQ_MASTER_RD;
            r_idx         <= 2'd0;
            r_cmd         <= 4'b0000;
            r_wdata       <= '0;
            r_done        <= 4'b0000;
            r_rdata       <= '0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_done <= 4'b0000;

            if (w_issue) begin
                r_idx  <= w_winner;
                r_last <= w_winner;
                r_cmd  <= onehot4(w_winner);
                r_cnt  <= '0;
                if (w_winner == REQ_SLAVE_WR) begin
                    r_wdata <= wdata_slave;
                end else if (w_winner == REQ_MASTER_WR) begin
                    r_wdata <= wdata_master;
                end
            end else if (r_state == WAIT_HINT && r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_complete) begin
                r_cmd  <= 4'b0000;
                r_done <= onehot4(r_idx);
                if (r_idx[0]) begin
                    r_rdata <= sram_rdata;
                end
            end

            if (w_abort) begin
                r_cmd <= 4'b0000;
            end

            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign sram_cmd    = r_cmd;
    assign sram_wdata  = r_wdata;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
